// File: rtl/apb_master_cmd.sv
// Command-driven APB master: 2-entry command FIFO feeding an IDLE/SETUP/ACCESS
// sequencer with back-to-back transfers and a bounded ACCESS-phase timeout.
module apb_master_cmd #(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       busy,
    output logic       sel,
    output logic       enable,
    output logic       write,
    output logic [7:0] addr,
    output logic [7:0] wdata,
    input  logic [7:0] rdata,
    input  logic       ready
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [1:0]  count;
    logic        rd_ptr;
    logic        wr_ptr;
    logic [16:0] mem [2];
    logic [16:0] head;
    logic [7:0]  wait_cnt;
    logic        push;
    logic        pop;
    logic        done;

    // cmd_ready depends only on the registered count, never on a same-cycle pop
    assign cmd_ready = (count < 2'd2);
    assign push      = cmd_valid && cmd_ready;
    assign busy      = (state != ST_IDLE) || (count != 2'd0);
    assign head      = mem[rd_ptr];
    assign done      = ready || (wait_cnt == WAIT_LAST);

    always_comb begin
        pop = 1'b0;
        case (state)
            ST_IDLE:   pop = (count != 2'd0);
            ST_ACCESS: pop = done && (count != 2'd0);
            default:   pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            wait_cnt  <= 8'd0;
            sel       <= 1'b0;
            enable    <= 1'b0;
            write     <= 1'b0;
            addr      <= 8'd0;
            wdata     <= 8'd0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 8'd0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    enable <= 1'b0;
                    if (pop) begin
                        write <= head[16];
                        addr  <= head[15:8];
                        wdata <= head[16] ? head[7:0] : 8'd0;
                        sel   <= 1'b1;
                        state <= ST_SETUP;
                    end else begin
                        sel <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    enable   <= 1'b1;
                    wait_cnt <= 8'd0;
                    state    <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (done) begin
                        // Completion or timeout abort; an abort reports err with zero data
                        enable    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= !ready;
                        rsp_rdata <= (ready && !write) ? rdata : 8'd0;
                        if (pop) begin
                            write <= head[16];
                            addr  <= head[15:8];
                            wdata <= head[16] ? head[7:0] : 8'd0;
                            sel   <= 1'b1;
                            state <= ST_SETUP;
                        end else begin
                            sel   <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    sel    <= 1'b0;
                    enable <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_cmd.sv
// Bench for apb_master_cmd: table-driven transfers through a scoreboard and an
// APB slave model, plus hand-written latency, back-to-back, timeout and reset sequences.
module tb_apb_master_cmd;

    localparam int TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_addr = 8'd0;
    logic [7:0] cmd_wdata = 8'd0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       busy;
    logic       sel;
    logic       enable;
    logic       write;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata = 8'd0;
    logic       ready = 1'b0;

    always #5 clk = ~clk;

    apb_master_cmd #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .sel       (sel),
        .enable    (enable),
        .write     (write),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ready     (ready)
    );

    typedef struct {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
    } apb_t;

    typedef struct {
        logic       err;
        logic [7:0] rd;
    } rsp_t;

    typedef struct {
        int         waits;
        logic [7:0] rd;
    } slv_t;

    typedef struct {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] rd;
        int         waits;
        logic       exp_err;
        logic [7:0] exp_rd;
    } vec_t;

    apb_t apb_q[$];
    rsp_t rsp_q[$];
    slv_t slv_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // APB slave model and response scoreboard, sampled on the falling edge
    apb_t       cur = '{1'b0, 8'h00, 8'h00};
    int         cur_waits = 0;
    logic [7:0] cur_rd = 8'h00;
    int         acc = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            apb_q.delete();
            rsp_q.delete();
            slv_q.delete();
            ready     <= 1'b0;
            rdata     <= 8'h00;
            acc       <= 0;
            cur_waits <= 0;
            cur_rd    <= 8'h00;
        end else begin
            if (sel && !enable) begin
                check("setup_expected", 32'(apb_q.size() != 0), 1);
                if (apb_q.size() != 0 && slv_q.size() != 0) begin
                    check("setup_write", 32'(write), 32'(apb_q[0].w));
                    check("setup_addr", 32'(addr), 32'(apb_q[0].a));
                    check("setup_wdata", 32'(wdata), 32'(apb_q[0].d));
                    cur       <= apb_q[0];
                    cur_waits <= slv_q[0].waits;
                    cur_rd    <= slv_q[0].rd;
                    void'(apb_q.pop_front());
                    void'(slv_q.pop_front());
                end
                acc   <= 0;
                ready <= 1'b0;
            end else if (sel && enable) begin
                check("access_write_stable", 32'(write), 32'(cur.w));
                check("access_addr_stable", 32'(addr), 32'(cur.a));
                check("access_wdata_stable", 32'(wdata), 32'(cur.d));
                ready <= (acc == cur_waits);
                rdata <= (acc == cur_waits) ? cur_rd : (cur_rd ^ 8'hFF);
                acc   <= acc + 1;
            end else begin
                ready <= 1'b0;
            end
            if (rsp_valid) begin
                check("rsp_expected", 32'(rsp_q.size() != 0), 1);
                if (rsp_q.size() != 0) begin
                    check("rsp_err", 32'(rsp_err), 32'(rsp_q[0].err));
                    check("rsp_rdata", 32'(rsp_rdata), 32'(rsp_q[0].rd));
                    void'(rsp_q.pop_front());
                end
            end
        end
    end

    // Called on a falling edge; returns on the falling edge after the accepting edge
    task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] rd, input int waits,
                        input logic e_err, input logic [7:0] e_rd);
        int guard;
        guard     = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!cmd_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("send_accept_bound", 0, 1);
        @(posedge clk);
        apb_q.push_back('{w, a, w ? d : 8'h00});
        rsp_q.push_back('{e_err, e_rd});
        slv_q.push_back('{waits, rd});
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((busy || rsp_q.size() != 0) && g < 300) begin
            @(negedge clk);
            g++;
        end
        check("drain_done", 32'(g < 300), 1);
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_sel"}, 32'(sel), 0);
        check({tag, "_enable"}, 32'(enable), 0);
        check({tag, "_write"}, 32'(write), 0);
        check({tag, "_addr"}, 32'(addr), 0);
        check({tag, "_wdata"}, 32'(wdata), 0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 0);
        check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 0);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic latency_seq(input string tag);
        send(1'b1, 8'h41, 8'h05, 8'h00, 0, 1'b0, 8'h00);
        check({tag, "_n0_sel"}, 32'(sel), 0);
        check({tag, "_n0_busy"}, 32'(busy), 1);
        @(negedge clk);
        check({tag, "_n1_sel"}, 32'(sel), 1);
        check({tag, "_n1_enable"}, 32'(enable), 0);
        check({tag, "_n1_write"}, 32'(write), 1);
        check({tag, "_n1_addr"}, 32'(addr), 32'h41);
        check({tag, "_n1_wdata"}, 32'(wdata), 32'h05);
        @(negedge clk);
        check({tag, "_n2_sel"}, 32'(sel), 1);
        check({tag, "_n2_enable"}, 32'(enable), 1);
        check({tag, "_n2_rsp_valid"}, 32'(rsp_valid), 0);
        @(negedge clk);
        check({tag, "_n3_rsp_valid"}, 32'(rsp_valid), 1);
        check({tag, "_n3_rsp_err"}, 32'(rsp_err), 0);
        check({tag, "_n3_rsp_rdata"}, 32'(rsp_rdata), 0);
        check({tag, "_n3_enable"}, 32'(enable), 0);
        check({tag, "_n3_sel"}, 32'(sel), 0);
        check({tag, "_n3_write_hold"}, 32'(write), 1);
        check({tag, "_n3_addr_hold"}, 32'(addr), 32'h41);
        @(negedge clk);
        check({tag, "_n4_rsp_valid"}, 32'(rsp_valid), 0);
    endtask

    task automatic run_until_rsp(output int en_cycles, output logic got);
        en_cycles = 0;
        got       = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (enable) en_cycles++;
            if (rsp_valid) got = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   en_cycles;
        logic got;
        int   pulses;
        int   setups;
        logic sel_held;
        logic found;

        vecs[0] = '{1'b1, 8'h41, 8'h05, 8'h00, 0,   1'b0, 8'h00};
        vecs[1] = '{1'b0, 8'h41, 8'hEE, 8'h05, 3,   1'b0, 8'h05};
        vecs[2] = '{1'b0, 8'hC3, 8'h11, 8'hA5, 0,   1'b0, 8'hA5};
        vecs[3] = '{1'b1, 8'h80, 8'hFF, 8'h5A, 1,   1'b0, 8'h00};
        vecs[4] = '{1'b0, 8'h81, 8'h00, 8'h77, 255, 1'b1, 8'h00};
        vecs[5] = '{1'b0, 8'h00, 8'h22, 8'h3C, 2,   1'b0, 8'h3C};
        vecs[6] = '{1'b1, 8'hFF, 8'h00, 8'h00, 3,   1'b0, 8'h00};
        vecs[7] = '{1'b0, 8'h7F, 8'h33, 8'hFF, 4,   1'b1, 8'h00};

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset("rst0");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset("rst0_released");

        latency_seq("lat");
        drain();

        for (int i = 0; i < 8; i++) begin
            send(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].rd, vecs[i].waits,
                 vecs[i].exp_err, vecs[i].exp_rd);
        end
        drain();

        // Read with three wait states
        send(1'b0, 8'h41, 8'h00, 8'h05, 3, 1'b0, 8'h05);
        run_until_rsp(en_cycles, got);
        check("wait3_rsp_seen", 32'(got), 1);
        check("wait3_enable_cycles", 32'(en_cycles), 4);
        check("wait3_rsp_rdata", 32'(rsp_rdata), 32'h05);
        check("wait3_rsp_err", 32'(rsp_err), 0);
        drain();

        // Three back-to-back commands
        send(1'b1, 8'h10, 8'hA1, 8'h00, 0, 1'b0, 8'h00);
        send(1'b0, 8'h50, 8'h00, 8'hB2, 0, 1'b0, 8'hB2);
        send(1'b1, 8'h90, 8'hC3, 8'h00, 0, 1'b0, 8'h00);
        check("b2b_cmd_ready_full", 32'(cmd_ready), 0);
        pulses   = 0;
        setups   = 0;
        sel_held = 1'b1;
        for (int i = 0; i < 30 && pulses < 3; i++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
            if (sel && !enable) setups++;
            if (pulses < 3 && !sel) sel_held = 1'b0;
        end
        check("b2b_pulses", 32'(pulses), 3);
        check("b2b_setups_enable_low", 32'(setups), 2);
        check("b2b_sel_continuous", 32'(sel_held), 1);
        check("b2b_sel_after", 32'(sel), 0);
        drain();

        // Timeout abort with a silent slave
        send(1'b0, 8'h81, 8'h00, 8'h66, 255, 1'b1, 8'h00);
        run_until_rsp(en_cycles, got);
        check("tmo_rsp_seen", 32'(got), 1);
        check("tmo_enable_cycles", 32'(en_cycles), TIMEOUT);
        check("tmo_rsp_err", 32'(rsp_err), 1);
        check("tmo_rsp_rdata", 32'(rsp_rdata), 0);
        check("tmo_sel_low", 32'(sel), 0);
        @(negedge clk);
        check("tmo_sel_after", 32'(sel), 0);
        drain();

        // Reset during ACCESS with a second command buffered
        send(1'b0, 8'h42, 8'h00, 8'h12, 255, 1'b1, 8'h00);
        send(1'b1, 8'hC4, 8'h9D, 8'h00, 0, 1'b0, 8'h00);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (enable) found = 1'b1;
            else @(negedge clk);
        end
        check("mid_access_reached", 32'(found), 1);
        check("mid_buffered", 32'(busy), 1);
        rst_n = 1'b0;
        #1 check_reset("mid_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_rst_no_sel", 32'(sel), 0);
            check("post_rst_no_rsp", 32'(rsp_valid), 0);
        end

        latency_seq("post_rst_lat");
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
